// File: rtl/ascon_pkg.sv
// Shared Ascon datapath types: five 64-bit words, word 0 first.
package ascon_pkg;

    parameter int unsigned WORD_WIDTH = 64;
    parameter int unsigned NUM_WORDS  = 5;

    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;

endpackage

// File: rtl/substitution_layer_folded.sv
// Folded Ascon substitution layer: LANES bit-slices per cycle, valid/ready on both sides.
// The working register doubles as the output, so results hold under backpressure for free.
module substitution_layer_folded
    import ascon_pkg::*;
#(
    parameter int unsigned LANES = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  ascon_state_t state_array_i,
    output logic         valid_o,
    input  logic         ready_i,
    output ascon_state_t state_array_o,
    output logic         busy_o
);

    localparam int unsigned STEPS = (LANES > 0) ? WORD_WIDTH / LANES : 1;
    localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned IdxW  = $clog2(WORD_WIDTH);

    if (LANES < 1 || (WORD_WIDTH % LANES) != 0) begin : g_bad_lanes
        $error("LANES must be >= 1 and divide WORD_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    ascon_state_t     st_q, st_d;

    logic [IdxW-1:0]            base;
    logic [4:0][LANES-1:0]      x, a, t, b, y;

    // Bit-sliced Ascon S-box applied to the current chunk of LANES slices.
    always_comb begin
        base = IdxW'(cnt_q) * IdxW'(LANES);
        x[0] = st_q[0][base +: LANES];
        x[1] = st_q[1][base +: LANES];
        x[2] = st_q[2][base +: LANES];
        x[3] = st_q[3][base +: LANES];
        x[4] = st_q[4][base +: LANES];

        a    = x;
        a[0] = x[0] ^ x[4];
        a[4] = x[4] ^ x[3];
        a[2] = x[2] ^ x[1];

        t[0] = ~a[0] & a[1];
        t[1] = ~a[1] & a[2];
        t[2] = ~a[2] & a[3];
        t[3] = ~a[3] & a[4];
        t[4] = ~a[4] & a[0];

        b[0] = a[0] ^ t[1];
        b[1] = a[1] ^ t[2];
        b[2] = a[2] ^ t[3];
        b[3] = a[3] ^ t[4];
        b[4] = a[4] ^ t[0];

        y[0] = b[0] ^ b[4];
        y[1] = b[1] ^ b[0];
        y[2] = ~b[2];
        y[3] = b[3] ^ b[2];
        y[4] = b[4];
    end

    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;

        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    st_d    = state_array_i;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                busy_o = 1'b1;
                st_d[0][base +: LANES] = y[0];
                st_d[1][base +: LANES] = y[1];
                st_d[2][base +: LANES] = y[2];
                st_d[3][base +: LANES] = y[3];
                st_d[4][base +: LANES] = y[4];
                if (cnt_q == CntW'(STEPS - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                valid_o = 1'b1;
                // Pass-through lets a new state be taken in the same cycle the result leaves.
                ready_o = ready_i;
                if (ready_i) begin
                    if (valid_i) begin
                        st_d    = state_array_i;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    assign state_array_o = st_q;

endmodule

// File: tb/tb_substitution_layer_folded.sv
// Scoreboard bench for substitution_layer_folded at LANES = 8, 1 and 64.
module tb_substitution_layer_folded;
    import ascon_pkg::*;

    localparam int NDUT = 3;

    function automatic int unsigned lanes_of(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            default: return 64;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic         vin  [NDUT];
    logic         rin  [NDUT];
    logic         rout [NDUT];
    logic         vout [NDUT];
    logic         bout [NDUT];
    ascon_state_t din  [NDUT];
    ascon_state_t dout [NDUT];

    int n_checks = 0;
    int n_errors = 0;
    ascon_state_t exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        substitution_layer_folded #(.LANES(lanes_of(g))) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .valid_i      (vin[g]),
            .ready_o      (rout[g]),
            .state_array_i(din[g]),
            .valid_o      (vout[g]),
            .ready_i      (rin[g]),
            .state_array_o(dout[g]),
            .busy_o       (bout[g])
        );
    end

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ascon_state_t ref_sub(input ascon_state_t s);
        logic [4:0] tbl [32];
        logic [4:0] i5, o5;
        ascon_state_t r;
        tbl = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        for (int j = 0; j < 64; j++) begin
            i5 = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            o5 = tbl[i5];
            r[0][j] = o5[4];
            r[1][j] = o5[3];
            r[2][j] = o5[2];
            r[3][j] = o5[1];
            r[4][j] = o5[0];
        end
        return r;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    // Waits for valid_o with a cycle budget; n starts at 1 on the negedge after the accept edge.
    task automatic wait_result(input int k, input string tag);
        int n;
        n = 1;
        while (!vout[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, WORD_WIDTH / lanes_of(k) + 1);
        if (vout[k]) check({tag, "_data"}, dout[k], exp_q.pop_front());
        else void'(exp_q.pop_front());
    endtask

    task automatic run_one(input int k, input ascon_state_t s, input string tag);
        @(negedge clk);
        check({tag, "_rdy"}, rout[k], 1);
        din[k] = s;
        vin[k] = 1'b1;
        exp_q.push_back(ref_sub(s));
        @(negedge clk);
        vin[k] = 1'b0;
        din[k] = rand_state();
        wait_result(k, tag);
    endtask

    task automatic run_stream(input int k, input string tag);
        int sent, got, cyc, last_t, steps;
        logic will_acc;
        steps = WORD_WIDTH / lanes_of(k);
        sent = 0;
        got = 0;
        last_t = -1;
        @(negedge clk);
        din[k] = rand_state();
        vin[k] = 1'b1;
        exp_q.push_back(ref_sub(din[k]));
        for (cyc = 0; cyc < 10 * (steps + 1) + 40 && got < 10; cyc++) begin
            will_acc = vin[k] && rout[k];
            @(negedge clk);
            if (vout[k]) begin
                check({tag, "_data"}, dout[k], exp_q.pop_front());
                if (last_t >= 0) check({tag, "_gap"}, cyc - last_t, steps + 1);
                last_t = cyc;
                got++;
            end
            if (will_acc) begin
                sent++;
                if (sent < 10) begin
                    din[k] = rand_state();
                    exp_q.push_back(ref_sub(din[k]));
                end else begin
                    vin[k] = 1'b0;
                end
            end
        end
        vin[k] = 1'b0;
        check({tag, "_count"}, got, 10);
        while (exp_q.size() > got - got) void'(exp_q.pop_front());
    endtask

    initial begin
        ascon_state_t s, snap;
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            vin[k] = 1'b0;
            rin[k] = 1'b1;
            din[k] = rand_state();
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ready", rout[k], 1);
            check("rst_valid", vout[k], 0);
            check("rst_busy", bout[k], 0);
            check("rst_data", dout[k], 0);
        end

        // All-zero state: only word 2 ends up all-ones.
        run_one(0, '0, "zero8");
        check("zero8_w2", dout[0][2], 64'hFFFF_FFFF_FFFF_FFFF);
        check("zero8_w0", dout[0][0], 0);

        for (int k = 0; k < NDUT; k++) begin
            run_one(k, '1, "ones");
            check("ones_w1", dout[k][1], 0);
            check("ones_w4", dout[k][4], 64'hFFFF_FFFF_FFFF_FFFF);
            for (int r = 0; r < 3; r++) run_one(k, rand_state(), "rand");
        end

        // Backpressure: hold the result, refuse input, then accept in the release cycle.
        @(negedge clk);
        rin[0] = 1'b0;
        s = rand_state();
        din[0] = s;
        vin[0] = 1'b1;
        exp_q.push_back(ref_sub(s));
        @(negedge clk);
        vin[0] = 1'b0;
        begin
            int n;
            n = 1;
            while (!vout[0] && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("bp_lat", n, 9);
        end
        snap = dout[0];
        for (int i = 0; i < 20; i++) begin
            vin[0] = 1'b1;
            din[0] = rand_state();
            @(negedge clk);
            check("bp_valid", vout[0], 1);
            check("bp_hold", dout[0], snap);
            check("bp_ready", rout[0], 0);
        end
        s = rand_state();
        din[0] = s;
        rin[0] = 1'b1;
        #1;
        check("bp_ready_pass", rout[0], 1);
        check("bp_data", dout[0], exp_q.pop_front());
        exp_q.push_back(ref_sub(s));
        @(negedge clk);
        vin[0] = 1'b0;
        check("bp_accepted", bout[0], 1);
        wait_result(0, "bp_next");

        for (int k = 0; k < NDUT; k++) run_stream(k, "stream");

        // Reset in BUSY at cnt=3 discards the state.
        @(negedge clk);
        din[0] = rand_state();
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", bout[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_valid", vout[0], 0);
        check("mid_busyclr", bout[0], 0);
        check("mid_ready", rout[0], 1);
        check("mid_data", dout[0], 0);
        run_one(0, rand_state(), "post_rst");

        check("q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/substitution_layer_folded.md
# substitution_layer_folded

Folded, handshaked successor to the combinational Ascon substitution layer. It applies the 5-bit Ascon S-box to `LANES` bit-slices per clock. A full 320-bit state is therefore substituted in `WORD_WIDTH/LANES` cycles, trading latency for area. It sits between the constant-addition and linear-diffusion stages of area-constrained permutation datapaths, and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- `LANES`, default 8: bit-slices substituted per cycle. Must be ≥1 and divide `ascon_pkg::WORD_WIDTH` (64); otherwise elaboration fails with `$error`.
- `STEPS`, derived (localparam), = `WORD_WIDTH/LANES`: cycles per state.

Ports:
- `clk_i`, input, 1 bit: clock. Everything is sampled on the rising edge.
- `rst_i`, input, 1 bit: reset, synchronous and active-high.
- `valid_i`, input, 1 bit: an input state is offered.
- `ready_o`, output, 1 bit: the block can accept an input state this cycle.
- `state_array_i`, input, `ascon_pkg::ascon_state_t`: input state, sampled on accept.
- `valid_o`, output, 1 bit: `state_array_o` holds a completed result.
- `ready_i`, input, 1 bit: downstream accepts the result.
- `state_array_o`, output, `ascon_pkg::ascon_state_t`: the working register, driven directly.
- `busy_o`, output, 1 bit: substitution is in progress.

## Operation
S-box and slice ordering:
- Slice j has input `{x[0][j],x[1][j],x[2][j],x[3][j],x[4][j]}`, with word 0 as the MSB. The output is written back with the same ordering.
- S-box values for inputs 0..31, in hex: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.

Datapath:
- Working register `st` (320 bits).
- Step counter `cnt`, width `$clog2(STEPS)`, minimum 1 bit.
- In BUSY, each cycle substitutes slices `j = cnt*LANES .. cnt*LANES+LANES-1` in place. All other slices hold their value.
- Chunks are processed in ascending order, LSB chunk first.

FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - `ready_o=1`.
  - On `valid_i`: load `st <= state_array_i`, set `cnt <= 0`, go to BUSY.
- BUSY:
  - `busy_o=1`, `ready_o=0`.
  - Substitute chunk `cnt`.
  - If `cnt==STEPS-1`, go to DONE; otherwise `cnt++`.
- DONE:
  - `valid_o=1`.
  - `st` holds until `ready_i`.
  - `ready_o = ready_i`. This is combinational from `ready_i` and enables back-to-back operation.
  - If `ready_i & valid_i`: load the new state, `cnt<=0`, go to BUSY.
  - If `ready_i & !valid_i`: go to IDLE. `st` is retained.

General rules:
- `valid_i` while `ready_o=0` is ignored. The input is not captured and the source must hold it.
- `state_array_i` may change freely when the block is not accepting.
- `state_array_o` shows partial results during BUSY. It is meaningful only while `valid_o=1`.
- Special case `LANES=64` (`STEPS=1`): BUSY lasts exactly one cycle.

## Timing
- Reset values of every output: `ready_o=1`, `valid_o=0`, `busy_o=0`, `state_array_o=0`. Internally, FSM=IDLE and `cnt=0`.
- Reset mid-operation (BUSY or DONE): the next edge forces the reset values. The in-flight state is discarded and no `valid_o` is produced.
- `rst_i` has priority over every handshake in the same cycle.
- Latency: input accepted at edge E0 ⇒ BUSY for `STEPS` cycles ⇒ `valid_o=1` in the cycle after edge E0+`STEPS`.
- Sustained throughput with `ready_i` held at 1: one state per `STEPS+1` cycles.
- Backpressure: `valid_o` and `state_array_o` remain stable for any number of cycles while `ready_i=0`.
- No combinational path from `state_array_i` to any output.
- The only combinational input-to-output path is `ready_i` → `ready_o`.

## Test plan
1. All-zero state, `LANES=8`:
   - `valid_o` rises 9 cycles after accept.
   - Output words 0, 1, 3 and 4 are 0; word 2 is `64'hFFFF_FFFF_FFFF_FFFF`.
2. All-ones state, `LANES` in {1, 8, 64}:
   - Output words 0, 2, 3 and 4 are all-ones; word 1 is 0.
   - Latency is 65, 9 and 2 cycles respectively.
3. Random states across all legal `LANES` values: result matches a bit-sliced reference model using the table above, on every slice.
4. `ready_i` held low for 20 cycles in DONE:
   - `valid_o` and `state_array_o` stay constant.
   - `ready_o=0`, and a `valid_i` presented meanwhile is not accepted.
   - On `ready_i=1` with `valid_i=1`, the next state is accepted in that same cycle.
5. Back-to-back stream of 10 states with `ready_i=1`:
   - One result every `STEPS+1` cycles, in order, all correct.
6. `rst_i` asserted in BUSY at `cnt=3`:
   - Next cycle: `valid_o=0`, `busy_o=0`, `ready_o=1`, `state_array_o=0`.
   - A subsequent transaction completes correctly.
